// File: rtl/riscv_bus_arbiter.sv
// riscv_bus_arbiter
//   Shares one single-port synchronous RAM between the instruction-fetch port
//   and the load/store port. At most one access is granted per cycle. Data
//   accesses win by default. A starvation counter forces a fetch grant after
//   STARVE_LIMIT consecutive data grants while a fetch is waiting.
//   Store data is lane-replicated with a byte mask. Load data is realigned
//   and zero-extended.
//
// Ports
//   clock, reset       rising-edge clock, asynchronous active-low reset
//   i_req/i_addr       fetch request (held until i_ready)
//   i_ready            fetch accepted this cycle (combinational)
//   i_rvalid/i_rdata   fetched word, one cycle after acceptance
//   d_req/d_we/d_addr/d_width/d_wdata
//                      load/store request (held until d_ready)
//   d_ready            data request accepted this cycle (combinational)
//   d_rvalid/d_rdata   load data, one cycle after acceptance
//   d_err              misaligned or illegal width, one cycle after acceptance
//   mem_en/mem_we/mem_addr/mem_wmask/mem_wdata/mem_rdata
//                      synchronous RAM port; read data arrives one cycle later
module riscv_bus_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ready,
  output logic                  i_rvalid,
  output logic [31:0]           i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [1:0]            d_width,
  input  logic [31:0]           d_wdata,
  output logic                  d_ready,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  output logic                  d_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wmask,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2,
    OWN_ERR  = 2'd3
  } owner_t;

  logic [3:0] starve_cnt;
  owner_t     owner_q;
  logic       is_read_q;
  logic [1:0] off_q;
  logic [1:0] width_q;

  logic grant_i;
  logic grant_d;
  logic d_bad;
  logic d_go;

  // Byte-lane enables for a store of the given width at the given offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] width, input logic [1:0] off);
    case (width)
      2'd0:    lane_mask = 4'b0001 << off;
      2'd1:    lane_mask = 4'b0011 << {off[1], 1'b0};
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data across all lanes it may land in.
  function automatic logic [31:0] lane_data(input logic [1:0] width, input logic [31:0] wd);
    case (width)
      2'd0:    lane_data = {4{wd[7:0]}};
      2'd1:    lane_data = {2{wd[15:0]}};
      default: lane_data = wd;
    endcase
  endfunction

  // Shift the addressed bytes down to bit 0 and zero-extend to 32 bits.
  function automatic logic [31:0] load_align(input logic [31:0] rd, input logic [1:0] off,
                                             input logic [1:0] width);
    logic [31:0] sh;
    sh = rd >> {off, 3'b000};
    case (width)
      2'd0:    load_align = {24'd0, sh[7:0]};
      2'd1:    load_align = {16'd0, sh[15:0]};
      default: load_align = sh;
    endcase
  endfunction

  // Grants are gated by reset so every output reads zero while reset is low.
  always_comb begin
    grant_i = reset & i_req & (~d_req | (starve_cnt == LIMIT));
    grant_d = reset & d_req & ~grant_i;
    case (d_width)
      2'd0:    d_bad = 1'b0;
      2'd1:    d_bad = d_addr[0];
      2'd2:    d_bad = (d_addr[1:0] != 2'b00);
      default: d_bad = 1'b1;
    endcase
  end

  // A misaligned data grant is acknowledged but never reaches the memory.
  assign d_go    = grant_d & ~d_bad;
  assign i_ready = grant_i;
  assign d_ready = grant_d;

  assign mem_en    = grant_i | d_go;
  assign mem_we    = d_go & d_we;
  assign mem_addr  = grant_i ? {i_addr[ADDR_WIDTH-1:2], 2'b00} :
                     d_go    ? {d_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_wmask = mem_we ? lane_mask(d_width, d_addr[1:0]) : 4'b0000;
  assign mem_wdata = mem_we ? lane_data(d_width, d_wdata) : 32'd0;

  // Fetches are always word reads; the low address bits carry no meaning.
  logic unused_i_addr;
  assign unused_i_addr = ^i_addr[1:0];

  // Accept stage -> response stage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
      owner_q    <= OWN_NONE;
      is_read_q  <= 1'b0;
      off_q      <= 2'd0;
      width_q    <= 2'd0;
    end else begin
      if (grant_i || !i_req)
        starve_cnt <= 4'd0;
      else if (grant_d && starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 4'd1;

      // Stores leave the owner at NONE so they produce no response pulse.
      if (grant_i)
        owner_q <= OWN_I;
      else if (grant_d && d_bad)
        owner_q <= OWN_ERR;
      else if (grant_d && !d_we)
        owner_q <= OWN_D;
      else
        owner_q <= OWN_NONE;

      is_read_q <= grant_d & ~d_we;
      off_q     <= d_addr[1:0];
      width_q   <= d_width;
    end
  end

  assign i_rvalid = (owner_q == OWN_I);
  assign i_rdata  = i_rvalid ? mem_rdata : 32'd0;
  assign d_rvalid = (owner_q == OWN_D) & is_read_q;
  assign d_rdata  = d_rvalid ? load_align(mem_rdata, off_q, width_q) : 32'd0;
  assign d_err    = (owner_q == OWN_ERR);

endmodule

// File: tb/tb_riscv_bus_arbiter.sv
module tb_riscv_bus_arbiter;

  localparam int AW    = 32;
  localparam int LIMIT = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_ready, i_rvalid;
  logic [31:0]   i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [1:0]    d_width = 2'd0;
  logic [31:0]   d_wdata = '0;
  logic          d_ready, d_rvalid, d_err;
  logic [31:0]   d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wmask;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  riscv_bus_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_width(d_width), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Environment RAM: 64 words, synchronous read, byte-masked write.
  logic [31:0] ram [64];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we)
        for (int k = 0; k < 4; k++)
          if (mem_wmask[k]) ram[mem_addr[7:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
      mem_rdata <= ram[mem_addr[7:2]];
    end
  end

  // Reference model: flat byte memory plus a count of data wins over a waiting fetch.
  logic [7:0] refmem [256];
  int         wins = 0;

  typedef struct {
    int          due;
    bit          is_i;
    bit          err;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [31:0] ref_read(input int a, input int n);
    logic [31:0] v;
    v = 32'd0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = refmem[(a + k) & 255];
    return v;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, ".i_ready"},  32'(i_ready),  32'd0);
    chk({tag, ".d_ready"},  32'(d_ready),  32'd0);
    chk({tag, ".i_rvalid"}, 32'(i_rvalid), 32'd0);
    chk({tag, ".d_rvalid"}, 32'(d_rvalid), 32'd0);
    chk({tag, ".d_err"},    32'(d_err),    32'd0);
    chk({tag, ".i_rdata"},  i_rdata,       32'd0);
    chk({tag, ".d_rdata"},  d_rdata,       32'd0);
    chk({tag, ".mem_en"},   32'(mem_en),   32'd0);
    chk({tag, ".mem_we"},   32'(mem_we),   32'd0);
    chk({tag, ".mem_addr"}, mem_addr,      32'd0);
    chk({tag, ".mem_wmask"}, 32'(mem_wmask), 32'd0);
    chk({tag, ".mem_wdata"}, mem_wdata,    32'd0);
  endtask

  // Drive one cycle of requests, then at the falling edge compare the
  // accept-cycle outputs against the model and queue the expected response.
  task automatic step(input bit ir, input int ia, input bit dr, input bit we, input int da,
                      input int wd, input logic [31:0] wdat, output bit gi, output bit gd);
    bit   bad;
    int   n, off;
    logic [3:0] emask;
    exp_t e;
    @(posedge clock);
    #1;
    i_req = ir; i_addr = AW'(ia);
    d_req = dr; d_we = we; d_addr = AW'(da); d_width = 2'(wd); d_wdata = wdat;
    @(negedge clock);
    gi = ir && (!dr || wins == LIMIT);
    gd = dr && !gi;
    chk("i_ready", 32'(i_ready), 32'(gi));
    chk("d_ready", 32'(d_ready), 32'(gd));
    bad = (wd == 3) || (wd == 1 && (da % 2) != 0) || (wd == 2 && (da % 4) != 0);
    n   = 1 << (wd % 4);
    off = da % 4;
    e.due = cyc + 1;
    if (gi) begin
      chk("fetch.mem_en", 32'(mem_en), 32'd1);
      chk("fetch.mem_we", 32'(mem_we), 32'd0);
      chk("fetch.mem_addr", mem_addr, 32'(ia - ia % 4));
      e.is_i = 1; e.err = 0; e.data = ref_read(ia - ia % 4, 4);
      exp_q.push_back(e);
    end else if (gd && bad) begin
      chk("bad.mem_en", 32'(mem_en), 32'd0);
      e.is_i = 0; e.err = 1; e.data = 32'd0;
      exp_q.push_back(e);
    end else if (gd) begin
      chk("data.mem_en", 32'(mem_en), 32'd1);
      chk("data.mem_we", 32'(mem_we), 32'(we));
      chk("data.mem_addr", mem_addr, 32'(da - off));
      if (we) begin
        emask = 4'd0;
        for (int k = 0; k < 4; k++) if (k >= off && k < off + n) emask[k] = 1'b1;
        chk("store.mem_wmask", 32'(mem_wmask), 32'(emask));
        for (int k = off; k < off + n; k++) begin
          chk("store.lane", 32'(mem_wdata[8*k +: 8]), 32'(wdat[8*(k-off) +: 8]));
          refmem[(da - off + k) & 255] = wdat[8*(k-off) +: 8];
        end
      end else begin
        chk("load.mem_wmask", 32'(mem_wmask), 32'd0);
        e.is_i = 0; e.err = 0; e.data = ref_read(da, n);
        exp_q.push_back(e);
      end
    end else begin
      chk("idle.mem_en", 32'(mem_en), 32'd0);
    end
    if (!mem_en) begin
      chk("off.mem_addr",  mem_addr,        32'd0);
      chk("off.mem_wmask", 32'(mem_wmask),  32'd0);
      chk("off.mem_wdata", mem_wdata,       32'd0);
    end
    if (!ir || gi) wins = 0;
    else if (gd && wins < LIMIT) wins++;
  endtask

  // Response monitor: pops the response due this cycle, if any.
  initial begin
    exp_t e;
    bit   ei, ed, ee;
    logic [31:0] edat;
    forever begin
      @(negedge clock);
      if (reset) begin
        ei = 0; ed = 0; ee = 0; edat = 32'd0;
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
          e = exp_q.pop_front();
          tests++; fails++;
          $display("FAIL resp.missing: response due at cycle %0d never seen (now %0d)", e.due, cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          e = exp_q.pop_front();
          ei = e.is_i; ee = !e.is_i && e.err; ed = !e.is_i && !e.err; edat = e.data;
        end
        chk("resp.i_rvalid", 32'(i_rvalid), 32'(ei));
        chk("resp.d_rvalid", 32'(d_rvalid), 32'(ed));
        chk("resp.d_err",    32'(d_err),    32'(ee));
        if (ei) chk("resp.i_rdata", i_rdata, edat);
        if (ed) chk("resp.d_rdata", d_rdata, edat);
      end
    end
  end

  initial begin
    bit gi, gd;
    bit pi, pd, pwe;
    int pia, pda, pw;
    logic [31:0] pwd;
    for (int k = 0; k < 256; k++) refmem[k] = 8'($urandom);
    for (int w = 0; w < 64; w++) ram[w] = ref_read(4 * w, 4);

    // Reset state with requests asserted.
    i_req = 1; d_req = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_all_zero("reset");
    @(posedge clock); #1;
    reset = 1; i_req = 0; d_req = 0;

    // Word round trip.
    step(0, 0, 1, 1, 'h10, 2, 32'hDEADBEEF, gi, gd);
    chk("sw.mem_wmask", 32'(mem_wmask), 32'hF);
    step(0, 0, 1, 0, 'h10, 2, 0, gi, gd);
    chk("lw.mem_addr", mem_addr, 32'h10);
    step(0, 0, 0, 0, 0, 0, 0, gi, gd);

    // Byte and half lanes.
    step(0, 0, 1, 1, 'h13, 0, 32'h000000A5, gi, gd);
    chk("sb.mem_wmask", 32'(mem_wmask), 32'h8);
    chk("sb.mem_wdata", mem_wdata, 32'hA5A5A5A5);
    step(0, 0, 1, 1, 'h10, 2, 32'h12345678, gi, gd);
    step(0, 0, 1, 0, 'h12, 1, 0, gi, gd);
    step(0, 0, 0, 0, 0, 0, 0, gi, gd);

    // Misaligned word load.
    step(0, 0, 1, 0, 'h21, 2, 0, gi, gd);
    chk("mis.d_ready", 32'(d_ready), 32'd1);
    chk("mis.mem_en",  32'(mem_en),  32'd0);
    step(0, 0, 0, 0, 0, 0, 0, gi, gd);

    // Starvation: both held high; fetch wins on cycles 4 and 9.
    for (int c = 0; c < 10; c++) begin
      step(1, 'h40, 1, 0, 'h20, 2, 0, gi, gd);
      chk("starve.i_ready", 32'(i_ready), 32'(c == 4 || c == 9));
      chk("starve.d_ready", 32'(d_ready), 32'(c != 4 && c != 9));
    end

    // Streams on a single port.
    for (int c = 0; c < 4; c++) step(0, 0, 1, 0, 4 * c, 2, 0, gi, gd);
    for (int c = 0; c < 4; c++) step(1, 4 * c + 1, 0, 0, 0, 0, 0, gi, gd);
    step(0, 0, 0, 0, 0, 0, 0, gi, gd);

    // Reset asserted right after a fetch is accepted.
    step(1, 'h80, 0, 0, 0, 0, 0, gi, gd);
    chk("rst.i_ready", 32'(i_ready), 32'd1);
    #1;
    reset = 0;
    d_req = 1;
    exp_q.delete();
    wins = 0;
    repeat (2) begin
      @(negedge clock);
      chk_all_zero("rstmid");
    end
    @(posedge clock); #1;
    reset = 1; i_req = 0; d_req = 0;
    step(0, 0, 0, 0, 0, 0, 0, gi, gd);
    chk("rstrel.i_rvalid", 32'(i_rvalid), 32'd0);

    // Randomized traffic with held requests.
    pi = 0; pd = 0; pia = 0; pda = 0; pw = 0; pwe = 0; pwd = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!pi && $urandom_range(0, 1) == 1) begin
        pi = 1; pia = int'($urandom_range(0, 255));
      end
      if (!pd && $urandom_range(0, 3) != 0) begin
        pd = 1; pwe = 1'($urandom); pw = int'($urandom_range(0, 3));
        pda = int'($urandom_range(0, 255)); pwd = $urandom;
        if ($urandom_range(0, 3) != 0) pda = pda - pda % (1 << pw);
        if (pw == 3 && $urandom_range(0, 3) != 0) pw = 2;
      end
      step(pi, pia, pd, pwe, pda, pw, pwd, gi, gd);
      if (gi) pi = 0;
      if (gd) pd = 0;
    end
    step(0, 0, 0, 0, 0, 0, 0, gi, gd);
    step(0, 0, 0, 0, 0, 0, 0, gi, gd);
    chk("drain.queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/riscv_bus_arbiter.md
# riscv_bus_arbiter

Shares one single-port synchronous RAM between the core's instruction-fetch port and its load/store port. Grants at most one access per cycle. Data accesses win by default; a starvation counter forces a fetch grant after a bounded run of data grants. Also generates byte-lane write masks and realigns and zero-extends read data; sign extension stays in the core.

## Interface
- ADDR_WIDTH, 32, byte-address width of both ports and the memory port
- STARVE_LIMIT, 4, maximum consecutive data grants while a fetch waits; legal range 1..15
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held stable until i_ready
- i_addr  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored
- i_ready  out  1  fetch accepted this cycle (combinational)
- i_rvalid  out  1  i_rdata valid; one cycle after acceptance
- i_rdata  out  32  fetched word
- d_req  in  1  data request; held stable until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data byte address
- d_width  in  2  0 byte, 1 half, 2 word, 3 illegal
- d_wdata  in  32  store data, right-aligned
- d_ready  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  load data valid; one cycle after acceptance
- d_rdata  out  32  load data, right-aligned, zero-extended
- d_err  out  1  misaligned or illegal-width request; one cycle after acceptance
- mem_en  out  1  memory access strobe
- mem_we  out  1  write strobe, qualified by mem_en
- mem_addr  out  ADDR_WIDTH  word-aligned address, {addr[ADDR_WIDTH-1:2], 2'b00}
- mem_wmask  out  4  byte-lane enables
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read data, valid the cycle after a mem_en read

## Operation
- **Grant, evaluated combinationally each cycle:**
  - grant_i = i_req & (!d_req | starve_cnt == STARVE_LIMIT)
  - grant_d = d_req & !grant_i
- **starve_cnt register:**
  - Increments when grant_d & i_req.
  - Clears when grant_i or !i_req.
  - Saturates at STARVE_LIMIT.
- **Misalignment (d_bad):** width 1 with addr[0]=1; width 2 with addr[1:0]!=0; width 3.
- **Granted misaligned data request:**
  - d_ready=1 but mem_en=0; the memory is not touched.
  - d_err=1 on the next cycle; d_rvalid stays 0.
- **Write mask for a store:**
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<{addr[1],1'b0}.
  - Word: 4'b1111.
- **Write data for a store:**
  - Byte: wdata[7:0] replicated ×4.
  - Half: wdata[15:0] replicated ×2.
  - Word: passed through.
- **Loads:** mem_wmask=0, mem_we=0.
- **Response register:** captured at each accept and holds {owner ∈ NONE/I/D/ERR, is_read, offset[1:0], width[1:0]}.
  - Next cycle, owner I gives i_rvalid=1 and i_rdata=mem_rdata.
  - Next cycle, owner D with is_read gives d_rvalid=1 and d_rdata=(mem_rdata>>(8·offset)) masked to 8/16/32 bits.
  - Next cycle, owner ERR gives d_err=1.
  - Stores produce no response pulse.
- **mem_wdata, mem_addr, mem_wmask when mem_en=0:** all zero.

## Timing
- Reset values: all outputs 0; starve_cnt 0; response owner NONE.
- Reset mid-access: a pending response is discarded, so no rvalid or err follows reset release.
- Throughput and latency:
  - One accept per cycle, back-to-back, on either port.
  - Read latency is 1 cycle from accept to rvalid.
  - A store is complete at its accept edge.
- Simultaneous i_req and d_req: exactly one ready per cycle. The loser keeps its request and is retried every cycle.
- Starvation bound: with d_req held continuously, a pending fetch is granted no later than the (STARVE_LIMIT+1)-th cycle of waiting.
- Response pulses are single-cycle. A new accept in the same cycle does not extend or merge them.

## Test plan
- **Word load round trip:** store d_addr=0x10, width 2, wdata=0xDEADBEEF; then load 0x10 → on the store cycle mem_wmask=4'b1111; on the load cycle mem_addr=0x10; next cycle d_rvalid=1, d_rdata=0xDEADBEEF.
- **Byte and half lanes:**
  - sb 0xA5 to 0x13 → mem_wmask=4'b1000, mem_wdata=0xA5A5A5A5.
  - lh 0x12 with memory word 0x12345678 → d_rdata=0x00001234.
- **Misaligned request:** lw at 0x21 → d_ready=1, mem_en=0; next cycle d_err=1, d_rvalid=0.
- **Starvation, STARVE_LIMIT=4:** d_req and i_req held high → d_ready high for cycles 0–3, i_ready at cycle 4, d_ready at cycle 5; starve_cnt reads 0 after the fetch grant.
- **Priority and interleave:**
  - d_req only → every cycle granted.
  - i_req only → every cycle granted, i_rvalid streaming each following cycle.
- **Reset mid-access:** fetch accepted, reset asserted in the same cycle → i_rvalid stays 0 through reset release; all outputs 0 while reset is low.
